// File: rtl/ce_synth_multi_if.sv
// Configuration and status bundle for ce_synth_multi: ratio writes and phase sync
// travel in from the master side; enable pulses, error flags and lock travel out.
interface ce_synth_multi_if #(
  parameter int CHANNELS = 6,
  parameter int ACC_W    = 32
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_wr;
  logic [CH_W-1:0]     cfg_ch;
  logic [ACC_W-1:0]    cfg_num;
  logic [ACC_W-1:0]    cfg_den;
  logic                sync;
  logic [CHANNELS-1:0] ce_out;
  logic [CHANNELS-1:0] cfg_err;
  logic                locked;

  modport master (
    output cfg_wr, cfg_ch, cfg_num, cfg_den, sync,
    input  ce_out, cfg_err, locked
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_num, cfg_den, sync,
    output ce_out, cfg_err, locked
  );
endinterface

// File: rtl/ce_synth_multi.sv
// Multi-channel fractional clock-enable synthesiser: each channel emits num pulses
// per den refclk cycles from a phase accumulator; locked mimics a PLL lock flag.
module ce_synth_multi #(
  parameter int CHANNELS    = 6,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024
) (
  input logic              refclk,
  input logic              rst,
  ce_synth_multi_if.slave  bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  function automatic logic ratio_active(input logic [ACC_W-1:0] num,
                                        input logic [ACC_W-1:0] den);
    return (den != {ACC_W{1'b0}}) && (num != {ACC_W{1'b0}}) && (num <= den);
  endfunction

  function automatic logic ratio_error(input logic [ACC_W-1:0] num,
                                       input logic [ACC_W-1:0] den);
    return (den != {ACC_W{1'b0}}) && ((num > den) || (num == {ACC_W{1'b0}}));
  endfunction

  logic [1:0]          r_rst_sync;
  logic [ACC_W-1:0]    r_num [CHANNELS];
  logic [ACC_W-1:0]    r_den [CHANNELS];
  logic [ACC_W-1:0]    r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ce;
  logic [CHANNELS-1:0] r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_locked;

  logic                w_soft_rst;
  logic                w_wr_valid;
  logic                w_lock_clr;
  logic [ACC_W-1:0]    w_num_nxt [CHANNELS];
  logic [ACC_W-1:0]    w_den_nxt [CHANNELS];
  logic [ACC_W-1:0]    w_acc_nxt [CHANNELS];
  logic [ACC_W:0]      w_sum     [CHANNELS];
  logic [ACC_W:0]      w_diff    [CHANNELS];
  logic [CHANNELS-1:0] w_ce_nxt;
  logic [CHANNELS-1:0] w_err_nxt;
  logic [CHANNELS-1:0] w_active;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_locked_nxt;

  // Reset release synchroniser; assertion still clears everything asynchronously
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_soft_rst = ~r_rst_sync[1];
  assign w_wr_valid = bus.cfg_wr && ({1'b0, bus.cfg_ch} < (CH_W + 1)'(CHANNELS));
  assign w_lock_clr = w_wr_valid || bus.sync;

  // Per-channel next state: write and sync clear the accumulator and mute the pulse
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_num_nxt[k] = r_num[k];
      w_den_nxt[k] = r_den[k];
      w_acc_nxt[k] = {ACC_W{1'b0}};
      w_ce_nxt[k]  = 1'b0;
      w_active[k]  = ratio_active(r_num[k], r_den[k]);
      w_sum[k]     = {1'b0, r_acc[k]} + {1'b0, r_num[k]};
      w_diff[k]    = w_sum[k] - {1'b0, r_den[k]};
      if (w_soft_rst) begin
        w_num_nxt[k] = {ACC_W{1'b0}};
        w_den_nxt[k] = {ACC_W{1'b0}};
      end else if (w_wr_valid && (CH_W'(k) == bus.cfg_ch)) begin
        w_num_nxt[k] = bus.cfg_num;
        w_den_nxt[k] = bus.cfg_den;
      end else if (bus.sync) begin
        w_acc_nxt[k] = {ACC_W{1'b0}};
      end else if (w_active[k]) begin
        if (w_sum[k] >= {1'b0, r_den[k]}) begin
          w_acc_nxt[k] = w_diff[k][ACC_W-1:0];
          w_ce_nxt[k]  = 1'b1;
        end else begin
          w_acc_nxt[k] = w_sum[k][ACC_W-1:0];
          w_ce_nxt[k]  = 1'b0;
        end
      end else begin
        w_acc_nxt[k] = {ACC_W{1'b0}};
      end
      w_err_nxt[k] = ratio_error(w_num_nxt[k], w_den_nxt[k]);
    end
  end

  // Lock counter saturates; locked is judged on the already-registered state
  always_comb begin
    if (w_soft_rst || w_lock_clr) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (r_cnt != LOCK_MAX) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
    if (w_soft_rst) begin
      w_locked_nxt = 1'b0;
    end else begin
      w_locked_nxt = (r_cnt == LOCK_MAX) && (r_err == {CHANNELS{1'b0}}) && (|w_active);
    end
  end

  // State and output registers
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_num[k] <= {ACC_W{1'b0}};
        r_den[k] <= {ACC_W{1'b0}};
        r_acc[k] <= {ACC_W{1'b0}};
      end
      r_ce     <= {CHANNELS{1'b0}};
      r_err    <= {CHANNELS{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_locked <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_num[k] <= w_num_nxt[k];
        r_den[k] <= w_den_nxt[k];
        r_acc[k] <= w_acc_nxt[k];
      end
      r_ce     <= w_ce_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  assign bus.ce_out  = r_ce;
  assign bus.cfg_err = r_err;
  assign bus.locked  = r_locked;
endmodule

// File: tb/tb_ce_synth_multi.sv
// Directed bench for ce_synth_multi with hand-computed pulse timing, error flags
// and lock behaviour, using a short lock window to keep the run brief.
module tb_ce_synth_multi;
  localparam int CHANNELS = 6;
  localparam int ACC_W    = 32;
  localparam int LOCK     = 32;

  logic refclk = 1'b0;
  logic rst    = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt;
  logic exp_bit;
  logic [5:0] exp_vec [6];

  ce_synth_multi_if #(.CHANNELS(CHANNELS), .ACC_W(ACC_W)) bus ();

  ce_synth_multi #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK)) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [31:0] num, input logic [31:0] den);
    bus.cfg_wr  = 1'b1;
    bus.cfg_ch  = 3'(ch);
    bus.cfg_num = num;
    bus.cfg_den = den;
    tick();
    bus.cfg_wr  = 1'b0;
  endtask

  function automatic logic pulse_6_25(input int i);
    return ((6 * i) / 25) != ((6 * (i - 1)) / 25);
  endfunction

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_ch = 3'd0; bus.cfg_num = 32'd0; bus.cfg_den = 32'd0; bus.sync = 1'b0;
    repeat (3) tick();
    check("rst_ce", bus.ce_out, 6'b000000);
    check("rst_err", bus.cfg_err, 6'b000000);
    check("rst_locked", bus.locked, 1'b0);
    rst = 1'b1;
    repeat (4) tick();

    // ch0 = 3/25: first pulse 9 cycles after the write edge, 3 per 25 cycles
    wr(0, 32'd3, 32'd25);
    check("ch0_wr_forced", bus.ce_out[0], 1'b0);
    repeat (8) tick();
    check("ch0_pre_first", bus.ce_out[0], 1'b0);
    tick();
    check("ch0_first", bus.ce_out[0], 1'b1);
    cnt = 0;
    for (int i = 10; i <= 34; i++) begin
      tick();
      cnt += int'(bus.ce_out[0]);
      if (i == 32) check("lock_w32", bus.locked, 1'b0);
      if (i == 33) check("lock_w33", bus.locked, 1'b1);
    end
    check("ch0_window", cnt, 3);

    // ch1 = 1/1 held high, ch2 = 0/0 disabled
    wr(1, 32'd1, 32'd1);
    check("ch1_forced", bus.ce_out[1], 1'b0);
    wr(2, 32'd0, 32'd0);
    check("ch1_high", bus.ce_out[1], 1'b1);
    check("ch12_err", bus.cfg_err, 6'b000000);
    check("lock_drop_wr", bus.locked, 1'b0);
    for (int i = 1; i <= 33; i++) begin
      tick();
      check("ch12_level", bus.ce_out[2:1], 2'b01);
      if (i == 32) check("lock_v32", bus.locked, 1'b0);
      if (i == 33) check("lock_v33", bus.locked, 1'b1);
    end

    // ch3 illegal 5/4 then legal 1/4
    wr(3, 32'd5, 32'd4);
    check("ch3_err_set", bus.cfg_err, 6'b001000);
    check("ch3_ce_bad", bus.ce_out[3], 1'b0);
    repeat (40) tick();
    check("ch3_err_hold", bus.cfg_err, 6'b001000);
    check("ch3_ce_bad_hold", bus.ce_out[3], 1'b0);
    check("lock_err", bus.locked, 1'b0);
    wr(3, 32'd1, 32'd4);
    check("ch3_err_clr", bus.cfg_err, 6'b000000);
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 3) check("ch3_c3", bus.ce_out[3], 1'b0);
      if (i == 4) check("ch3_c4", bus.ce_out[3], 1'b1);
      if (i == 5) check("ch3_c5", bus.ce_out[3], 1'b0);
      if (i == 8) check("ch3_c8", bus.ce_out[3], 1'b1);
      if (i == 32) check("lock_u32", bus.locked, 1'b0);
      if (i == 33) check("lock_u33", bus.locked, 1'b1);
    end

    // ch0 and ch4 at 6/25 with skewed phases, then sync aligns them
    wr(0, 32'd6, 32'd25);
    repeat (7) tick();
    wr(4, 32'd6, 32'd25);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    check("sync_forced", bus.ce_out, 6'b000000);
    for (int i = 1; i <= 50; i++) begin
      tick();
      exp_bit = pulse_6_25(i);
      check("sync_ch0", bus.ce_out[0], exp_bit);
      check("sync_ch4", bus.ce_out[4], exp_bit);
      if (i == 1) check("lock_s1", bus.locked, 1'b0);
      if (i == 32) check("lock_s32", bus.locked, 1'b0);
      if (i == 33) check("lock_s33", bus.locked, 1'b1);
    end

    // Out-of-range channel write is ignored
    wr(7, 32'd1, 32'd2);
    check("bad_ch_ce0", bus.ce_out[0], pulse_6_25(51));
    check("bad_ch_locked", bus.locked, 1'b1);
    for (int i = 52; i <= 56; i++) begin
      tick();
      check("bad_ch_ce0_run", bus.ce_out[0], pulse_6_25(i));
      check("bad_ch_ce4_run", bus.ce_out[4], pulse_6_25(i));
      check("bad_ch_lock_run", bus.locked, 1'b1);
      check("bad_ch_err", bus.cfg_err, 6'b000000);
    end

    // Simultaneous write of ch0 = 1/2 and sync
    exp_vec[0] = 6'b000000; exp_vec[1] = 6'b000010; exp_vec[2] = 6'b000011;
    exp_vec[3] = 6'b000010; exp_vec[4] = 6'b001011; exp_vec[5] = 6'b010010;
    bus.sync = 1'b1;
    wr(0, 32'd1, 32'd2);
    bus.sync = 1'b0;
    check("wrsync_x0", bus.ce_out, exp_vec[0]);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("wrsync_vec", bus.ce_out, exp_vec[i]);
      if (i == 1) check("wrsync_lock", bus.locked, 1'b0);
    end

    // Asynchronous reset mid-run
    repeat (33) tick();
    check("prerst_locked", bus.locked, 1'b1);
    check("prerst_ch1", bus.ce_out[1], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_ce", bus.ce_out, 6'b000000);
    check("async_err", bus.cfg_err, 6'b000000);
    check("async_locked", bus.locked, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_ce", bus.ce_out, 6'b000000);
    repeat (40) tick();
    check("post_rst_ce_idle", bus.ce_out, 6'b000000);
    check("post_rst_locked", bus.locked, 1'b0);
    wr(1, 32'd1, 32'd1);
    tick();
    check("post_rst_rewrite", bus.ce_out, 6'b000010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
